// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX and MEM/WB.
// Issues loads/stores over a req/gnt/rvalid data port with byte/halfword
// lane alignment, load sign/zero extension and an access timeout.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned accesses fault
// without a bus request; when undefined, offending low address bits are ignored).
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic [2:0]  funct3_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        reg_write_i,
  input  logic [4:0]  rd_addr_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic        wb_reg_write_o,
  output logic        fault_o,
  output logic [31:0] fault_addr_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [4:0]       rd_q, rd_d;
  logic [2:0]       f3_q, f3_d;
  logic             rw_q, rw_d;
  logic             wb_valid_d, wb_rw_d, fault_d;
  logic [31:0]      wb_data_d, fault_addr_d;
  logic [4:0]       wb_rd_d;

  logic [3:0]  lane_be_c;
  logic [31:0] lane_wdata_c;
  logic        misaligned_c;
  logic [7:0]  ld_byte_c;
  logic [15:0] ld_half_c;
  logic [31:0] ld_result_c;

  // Bus-facing signals are decodes of the state register or latched values
  assign stall_o      = (state_q != IDLE);
  assign dmem_req_o   = (state_q == REQ);
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = {addr_q[31:2], 2'b00};
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;

  // Store lane enables, replicated write data and misalignment detect
  always_comb begin
    lane_be_c    = 4'b1111;
    lane_wdata_c = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        lane_be_c    = 4'b0001 << alu_result_i[1:0];
        lane_wdata_c = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        lane_be_c    = alu_result_i[1] ? 4'b1100 : 4'b0011;
        lane_wdata_c = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
    misaligned_c = ((funct3_i[1:0] == 2'b01) && alu_result_i[0]) ||
                   ((funct3_i[1:0] == 2'b10) && (alu_result_i[1:0] != 2'b00));
  end

  // Load lane extraction and sign/zero extension from latched address/width
  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte_c = dmem_rdata_i[7:0];
      2'd1:    ld_byte_c = dmem_rdata_i[15:8];
      2'd2:    ld_byte_c = dmem_rdata_i[23:16];
      default: ld_byte_c = dmem_rdata_i[31:24];
    endcase
    ld_half_c = addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (f3_q)
      3'b000:  ld_result_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      3'b001:  ld_result_c = {{16{ld_half_c[15]}}, ld_half_c};
      3'b100:  ld_result_c = {24'd0, ld_byte_c};
      3'b101:  ld_result_c = {16'd0, ld_half_c};
      default: ld_result_c = dmem_rdata_i;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    rd_d         = rd_q;
    f3_d         = f3_q;
    rw_d         = rw_q;
    wb_valid_d   = 1'b0;
    wb_data_d    = wb_data_o;
    wb_rd_d      = wb_rd_addr_o;
    wb_rw_d      = 1'b0;
    fault_d      = 1'b0;
    fault_addr_d = fault_addr_o;
    case (state_q)
      IDLE: begin
        if (ex_valid_i) begin
          if (mem_read_i || mem_write_i) begin
            if (TRAP_EN && misaligned_c) begin
              wb_valid_d   = 1'b1;
              wb_rd_d      = rd_addr_i;
              fault_d      = 1'b1;
              fault_addr_d = alu_result_i;
            end else begin
              addr_d  = alu_result_i;
              be_d    = lane_be_c;
              wdata_d = lane_wdata_c;
              we_d    = mem_write_i;
              rd_d    = rd_addr_i;
              f3_d    = funct3_i;
              rw_d    = reg_write_i;
              cnt_d   = '0;
              state_d = REQ;
            end
          end else begin
            wb_valid_d = 1'b1;
            wb_data_d  = alu_result_i;
            wb_rd_d    = rd_addr_i;
            wb_rw_d    = reg_write_i;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_gnt_i && we_q) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          state_d    = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          wb_valid_d   = 1'b1;
          wb_rd_d      = rd_q;
          fault_d      = 1'b1;
          fault_addr_d = addr_q;
          state_d      = IDLE;
        end else if (dmem_gnt_i) begin
          state_d = WAIT_R;
        end
      end
      WAIT_R: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_rvalid_i) begin
          wb_valid_d = 1'b1;
          wb_data_d  = ld_result_c;
          wb_rd_d    = rd_q;
          wb_rw_d    = rw_q;
          state_d    = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          wb_valid_d   = 1'b1;
          wb_rd_d      = rd_q;
          fault_d      = 1'b1;
          fault_addr_d = addr_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Access latches, timeout counter and registered write-back/fault outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      addr_q         <= '0;
      be_q           <= '0;
      wdata_q        <= '0;
      we_q           <= 1'b0;
      rd_q           <= '0;
      f3_q           <= '0;
      rw_q           <= 1'b0;
      wb_valid_o     <= 1'b0;
      wb_data_o      <= '0;
      wb_rd_addr_o   <= '0;
      wb_reg_write_o <= 1'b0;
      fault_o        <= 1'b0;
      fault_addr_o   <= '0;
    end else begin
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      be_q           <= be_d;
      wdata_q        <= wdata_d;
      we_q           <= we_d;
      rd_q           <= rd_d;
      f3_q           <= f3_d;
      rw_q           <= rw_d;
      wb_valid_o     <= wb_valid_d;
      wb_data_o      <= wb_data_d;
      wb_rd_addr_o   <= wb_rd_d;
      wb_reg_write_o <= wb_rw_d;
      fault_o        <= fault_d;
      fault_addr_o   <= fault_addr_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized traffic
// compared against a behavioural lane/extension/timeout model.
module tb_mem_stage;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic [31:0] alu_result_i;
  logic [31:0] store_data_i;
  logic [2:0]  funct3_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic        reg_write_i;
  logic [4:0]  rd_addr_i;
  logic        stall_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_addr_o;
  logic        wb_reg_write_o;
  logic        fault_o;
  logic [31:0] fault_addr_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .funct3_i(funct3_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .reg_write_i(reg_write_i), .rd_addr_i(rd_addr_i), .stall_o(stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .wb_rd_addr_o(wb_rd_addr_o),
    .wb_reg_write_o(wb_reg_write_o), .fault_o(fault_o), .fault_addr_o(fault_addr_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: lanes and extension computed arithmetically
  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    case (f3[1:0])
      2'b00:   return 4'(1 << int'(a[1:0]));
      2'b01:   return 4'(3 << (2 * int'(a[1])));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return (d & 32'hFF) * 32'h0101_0101;
      2'b01:   return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * int'(a[1:0]))) & 32'hFF;
    h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
    case (f3)
      3'b000:  return b - ((b & 32'h80) * 2);
      3'b001:  return h - ((h & 32'h8000) * 2);
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
    return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alu(input logic [31:0] res, input logic [4:0] rd, input bit rw);
    check("alu_pre_stall", 32'(stall_o), 0);
    ex_valid_i = 1'b1; mem_read_i = 1'b0; mem_write_i = 1'b0;
    alu_result_i = res; rd_addr_i = rd; reg_write_i = rw;
    step();
    ex_valid_i = 1'b0;
    check("alu_wb_valid", 32'(wb_valid_o), 1);
    check("alu_wb_data", wb_data_o, res);
    check("alu_wb_rd", 32'(wb_rd_addr_o), 32'(rd));
    check("alu_wb_rw", 32'(wb_reg_write_o), 32'(rw));
    check("alu_stall", 32'(stall_o), 0);
    check("alu_fault", 32'(fault_o), 0);
  endtask

  // g: cycle index (from 0 = first REQ cycle) at which gnt is given;
  // d: extra WAIT_R cycles before rvalid for loads.
  task automatic do_mem(input bit is_load, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] rd, input bit rw,
                        input int g, input int d, input logic [31:0] rdata);
    int  k;
    bit  done;
    ex_valid_i = 1'b1; mem_read_i = is_load; mem_write_i = !is_load;
    alu_result_i = a; store_data_i = sd; funct3_i = f3; rd_addr_i = rd; reg_write_i = rw;
`ifdef MEM_MISALIGN_TRAP_EN
    if (is_mis(f3, a)) begin
      step();
      ex_valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
      check("mis_req", 32'(dmem_req_o), 0);
      check("mis_stall", 32'(stall_o), 0);
      check("mis_wb_valid", 32'(wb_valid_o), 1);
      check("mis_fault", 32'(fault_o), 1);
      check("mis_fault_addr", fault_addr_o, a);
      check("mis_wb_rw", 32'(wb_reg_write_o), 0);
      return;
    end
`endif
    if (is_load) done = (g + 1 + d <= int'(T) - 1);
    else         done = (g <= int'(T) - 1);
    if (done) k = is_load ? g + 1 + d : g;
    else      k = int'(T) - 1;
    step();
    for (int i = 0; i <= k; i++) begin
      check("acc_stall", 32'(stall_o), 1);
      check("acc_req", 32'(dmem_req_o), 32'(i <= g));
      check("acc_wb_valid", 32'(wb_valid_o), 0);
      if (i == 0) begin
        check("acc_addr", dmem_addr_o, a & 32'hFFFF_FFFC);
        check("acc_we", 32'(dmem_we_o), 32'(!is_load));
        check("acc_be", 32'(dmem_be_o), 32'(exp_be(f3, a)));
        if (!is_load) check("acc_wdata", dmem_wdata_o, exp_wdata(f3, sd));
      end
      dmem_gnt_i = (i == g);
      if (is_load && i == g + 1 + d) begin
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = rdata;
      end else if (i <= g) begin
        dmem_rvalid_i = 1'($urandom_range(0, 1));
        dmem_rdata_i  = $urandom;
      end else begin
        dmem_rvalid_i = 1'b0;
      end
      step();
    end
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    ex_valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    check("ret_wb_valid", 32'(wb_valid_o), 1);
    check("ret_stall", 32'(stall_o), 0);
    check("ret_fault", 32'(fault_o), 32'(!done));
    check("ret_wb_rw", 32'(wb_reg_write_o), 32'(done && is_load && rw));
    if (!done) check("ret_fault_addr", fault_addr_o, a);
    if (done && is_load) begin
      check("ret_load_data", wb_data_o, exp_load(f3, a, rdata));
      check("ret_load_rd", 32'(wb_rd_addr_o), 32'(rd));
    end
    if (!done) begin
      dmem_rvalid_i = 1'b1; dmem_rdata_i = $urandom;
      step();
      dmem_rvalid_i = 1'b0;
      check("late_rvalid_wb", 32'(wb_valid_o), 0);
      check("late_rvalid_stall", 32'(stall_o), 0);
    end
  endtask

  initial begin
    logic [2:0]  lf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [31:0] a, sd, rdv;
    logic [4:0]  rd;
    bit          rw;
    int          g, d, kind;

    rst = 1'b1; ex_valid_i = 1'b0; alu_result_i = '0; store_data_i = '0; funct3_i = '0;
    mem_read_i = 1'b0; mem_write_i = 1'b0; reg_write_i = 1'b0; rd_addr_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    step(); step();
    check("rst_stall", 32'(stall_o), 0);
    check("rst_req", 32'(dmem_req_o), 0);
    check("rst_wb_valid", 32'(wb_valid_o), 0);
    check("rst_wb_data", wb_data_o, 0);
    check("rst_fault", 32'(fault_o), 0);
    check("rst_be", 32'(dmem_be_o), 0);
    @(negedge clk) rst = 1'b0;
    step();

    // Directed cases
    do_alu(32'h0000_1234, 5'd5, 1'b1);
    do_mem(1'b0, 3'b000, 32'h103, 32'hA5, 5'd3, 1'b1, 3, 0, 0);
    do_mem(1'b1, 3'b000, 32'h102, 32'h0, 5'd7, 1'b1, 0, 1, 32'h0080_0000);
    do_mem(1'b1, 3'b100, 32'h102, 32'h0, 5'd8, 1'b1, 1, 0, 32'h0080_0000);
    do_mem(1'b1, 3'b101, 32'h102, 32'h0, 5'd9, 1'b1, 0, 0, 32'hBEEF_0000);
    do_mem(1'b1, 3'b010, 32'h380, 32'h0, 5'd1, 1'b1, 20, 0, 32'h0);
    do_mem(1'b1, 3'b010, 32'h384, 32'h0, 5'd1, 1'b1, 1, 20, 32'h0);
    do_mem(1'b1, 3'b010, 32'h206, 32'h0, 5'd4, 1'b1, 0, 0, 32'hCAFE_F00D);
    do_mem(1'b0, 3'b001, 32'h20A, 32'h1234_5678, 5'd2, 1'b1, 0, 0, 0);
    // Completion exactly at expiry, and load grant at expiry
    do_mem(1'b1, 3'b001, 32'h40, 32'h0, 5'd11, 1'b1, 0, int'(T) - 2, 32'h8001_7FFF);
    do_mem(1'b0, 3'b010, 32'h44, 32'hDEAD_BEEF, 5'd12, 1'b0, int'(T) - 1, 0, 0);
    do_mem(1'b1, 3'b010, 32'h48, 32'h0, 5'd13, 1'b1, int'(T) - 1, 0, 32'h0);

    // Reset while in WAIT_R
    ex_valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010;
    alu_result_i = 32'h500; rd_addr_i = 5'd6; reg_write_i = 1'b1;
    step();
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    check("pre_rst_stall", 32'(stall_o), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_req", 32'(dmem_req_o), 0);
    check("arst_stall", 32'(stall_o), 0);
    check("arst_wb_valid", 32'(wb_valid_o), 0);
    check("arst_wb_data", wb_data_o, 0);
    check("arst_wb_rd", 32'(wb_rd_addr_o), 0);
    check("arst_fault_addr", fault_addr_o, 0);
    ex_valid_i = 1'b0; mem_read_i = 1'b0;
    @(negedge clk) rst = 1'b0;
    step();
    do_alu(32'h0BAD_F00D, 5'd31, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 3);
      a = $urandom; sd = $urandom; rdv = $urandom;
      rd = 5'($urandom); rw = 1'($urandom);
      g = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 2);
      d = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 2);
      if (kind == 0)      do_alu(a, rd, rw);
      else if (kind == 1) do_mem(1'b0, 3'($urandom_range(0, 2)), a, sd, rd, rw, g, d, rdv);
      else                do_mem(1'b1, lf[$urandom_range(0, 4)], a, sd, rd, rw, g, d, rdv);
      if ($urandom_range(0, 3) == 0) begin
        step();
        check("idle_gap_wb", 32'(wb_valid_o), 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage that sits directly downstream of the EX stage and consumes its ALU result, store data and control signals.
- Runs loads and stores over a request/grant/response data-memory port, with byte/halfword lane alignment and load sign/zero extension.
- Stalls upstream while an access is outstanding and delivers a registered result to the MEM/WB path.
- Non-memory instructions pass through with 1-cycle latency.

Parameters:
- TIMEOUT_CYCLES, 64: cycles an access may remain outstanding (REQ+WAIT_R) before it is aborted with a fault; minimum 2.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- ex_valid_i  input  1  valid instruction present at the stage inputs
- alu_result_i  input  32  EX result; this is the effective address for loads and stores
- store_data_i  input  32  forwarded rs2 data for stores
- funct3_i  input  3  width/sign select: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- mem_read_i  input  1  load
- mem_write_i  input  1  store; mem_read_i and mem_write_i are never both 1
- reg_write_i  input  1  instruction writes rd
- rd_addr_i  input  5  destination register
- stall_o  output  1  upstream must hold its inputs stable
- dmem_req_o  output  1  request valid
- dmem_we_o  output  1  1=store
- dmem_addr_o  output  32  word-aligned address {addr[31:2],2'b00}
- dmem_be_o  output  4  byte enables
- dmem_wdata_o  output  32  lane-replicated store data
- dmem_gnt_i  input  1  request accepted
- dmem_rvalid_i  input  1  load data valid
- dmem_rdata_i  input  32  load data word
- wb_valid_o  output  1  one-cycle pulse per retired instruction
- wb_data_o  output  32  result to MEM/WB
- wb_rd_addr_o  output  5  destination register
- wb_reg_write_o  output  1  register write enable
- fault_o  output  1  one-cycle fault pulse
- fault_addr_o  output  32  faulting effective address

Behaviour:
- Reset: state=IDLE; all outputs 0; timeout counter 0. Reset mid-access abandons the transaction and drops dmem_req_o asynchronously.
- stall_o = (state != IDLE). Instructions are accepted only in IDLE with ex_valid_i=1.
- Non-memory instruction, IDLE: at the edge, wb_data_o=alu_result_i, wb_rd_addr_o/wb_reg_write_o are copied from the inputs, wb_valid_o=1 for 1 cycle. State stays IDLE.
- Memory instruction, IDLE: at the edge, latch address, lanes, rd and funct3; drive dmem_* from registers; go to REQ; clear the counter.
- REQ:
  - dmem_req_o=1, with addr/be/wdata/we held stable until dmem_gnt_i.
  - On gnt for a store: retire next edge (wb_valid_o=1, wb_reg_write_o=0), go to IDLE.
  - On gnt for a load: go to WAIT_R.
  - dmem_rvalid_i is ignored in REQ.
- WAIT_R:
  - dmem_req_o=0.
  - On dmem_rvalid_i: extract the lane and extend, then retire with wb_data_o=result, wb_reg_write_o=reg_write_i latched value. Go to IDLE.
- Lanes (off=addr[1:0]):
  - SB: be=0001<<off, wdata=4x byte.
  - SH: be=0011 (addr[1]=0) or 1100, wdata=2x half.
  - SW: be=1111.
  - LB/LBU: select byte off. LH/LHU: select half addr[1]. Sign- or zero-extend to 32 bits.
- Timeout:
  - The counter increments each cycle in REQ/WAIT_R.
  - At count TIMEOUT_CYCLES-1 without completion, the access is aborted: next edge wb_valid_o=1, wb_reg_write_o=0, fault_o=1, fault_addr_o=addr; go to IDLE.
  - Completion in the same cycle as expiry takes priority over the fault.
  - A late rvalid in IDLE is ignored.
- wb_data_o, wb_rd_addr_o and fault_addr_o hold their values between pulses.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - Misaligned accesses issue no bus request and stay in IDLE: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Next edge: wb_valid_o=1, wb_reg_write_o=0, fault_o=1, fault_addr_o=addr.
- Undefined:
  - Offending low bits are ignored: a halfword uses addr[1]; a word uses be=1111.
  - No misalignment fault is raised; faults come only from timeout.

Test Plan:
- ADD result 0x0000_1234, rd=5 in IDLE -> next cycle wb_valid_o=1, wb_data_o=0x1234, wb_rd_addr_o=5, stall_o stays 0.
- SB addr 0x103, data 0xA5 -> dmem_be_o=1000, dmem_wdata_o=0xA5A5A5A5, dmem_addr_o=0x100; gnt after 3 cycles -> stall_o high 4 cycles, wb_reg_write_o=0.
- LB addr 0x102, rdata 0x0080_0000 -> wb_data_o=0xFFFF_FF80; LBU same -> 0x0000_0080; LHU addr 0x102 rdata 0xBEEF_0000 -> 0x0000_BEEF.
- Load with gnt but no rvalid, TIMEOUT_CYCLES=8 -> fault_o pulse after 8 cycles in REQ/WAIT_R, fault_addr_o=address, wb_reg_write_o=0; later rvalid ignored.
- LW addr 0x206 -> with MEM_MISALIGN_TRAP_EN: no dmem_req_o, fault_o=1 next cycle; without it: dmem_addr_o=0x204, be=1111, normal load.
- rst asserted while in WAIT_R -> dmem_req_o, stall_o and wb_* go 0 immediately; a fresh ADD after release retires normally.
